// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the 5Rs/10Rs sensors, queues coins
// in a small FIFO and emits one-cycle coin codes with enforced idle spacing.
module coin_acceptor #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int GAP_CYC      = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            coin5_raw,
    input  logic                            coin10_raw,
    input  logic                            hold,
    output logic [1:0]                      coin_code,
    output logic                            reject,
    output logic                            reject_jam,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    // Index 0 is the 5Rs sensor, index 1 the 10Rs sensor.
    logic [1:0]    sync1_r, sync2_r, deb_r, deb_d_r, evt_r;
    logic [CW-1:0] cnt_r [2];

    logic [1:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [LW-1:0] level_r;

    state_t        state_r, state_s;
    logic [GW-1:0] gap_r, gap_s;
    logic [1:0]    code_r, code_s;
    logic          reject_r, reject_jam_r;

    logic          jam_s, push_req_s, do_push_s, drop_s, pop_s;
    logic          full_s, empty_s, can_pop_s;
    logic [1:0]    push_code_s;

    // Synchroniser, debounce counters and registered rising-edge events.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            evt_r   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= {coin10_raw, coin5_raw};
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (cnt_r[i] == CW'(DEBOUNCE_CYC - 1)) begin
                        deb_r[i] <= sync2_r[i];
                        cnt_r[i] <= '0;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CW'(1);
                    end
                end else begin
                    cnt_r[i] <= '0;
                end
            end
            deb_d_r <= deb_r;
            evt_r   <= deb_r & ~deb_d_r;
        end
    end

    // Push/jam/drop decisions; a full queue still accepts a coin when it pops on the same edge.
    always_comb begin
        jam_s       = evt_r[0] & evt_r[1];
        push_req_s  = evt_r[0] ^ evt_r[1];
        push_code_s = evt_r[0] ? 2'b01 : 2'b10;
        full_s      = (level_r == LW'(FIFO_DEPTH));
        empty_s     = (level_r == LW'(0));
        can_pop_s   = ~empty_s & ~hold;
        do_push_s   = push_req_s & (~full_s | pop_s);
        drop_s      = push_req_s & full_s & ~pop_s;
    end

    // Coin queue storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_code_s;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Emitter next state. The last GAP cycle doubles as the IDLE decision so that exactly
    // GAP_CYC zero cycles separate back-to-back codes.
    always_comb begin
        state_s = state_r;
        gap_s   = gap_r;
        code_s  = 2'b00;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (can_pop_s && (gap_r == GW'(0))) begin
                    pop_s   = 1'b1;
                    code_s  = mem_r[rd_ptr_r];
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                gap_s   = GW'(GAP_CYC);
                state_s = ST_GAP;
            end
            ST_GAP: begin
                if (gap_r <= GW'(1)) begin
                    gap_s = GW'(0);
                    if (can_pop_s) begin
                        pop_s   = 1'b1;
                        code_s  = mem_r[rd_ptr_r];
                        state_s = ST_EMIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    gap_s = gap_r - GW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                gap_s   = GW'(0);
            end
        endcase
    end

    // Emitter state, gap counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            gap_r        <= '0;
            code_r       <= 2'b00;
            reject_r     <= 1'b0;
            reject_jam_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            gap_r        <= gap_s;
            code_r       <= code_s;
            reject_r     <= jam_s | drop_s;
            reject_jam_r <= jam_s;
        end
    end

    assign coin_code  = code_r;
    assign reject     = reject_r;
    assign reject_jam = reject_jam_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor with DEBOUNCE_CYC=16, GAP_CYC=2, FIFO_DEPTH=4.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin5_raw, coin10_raw, hold;
    logic [1:0] coin_code;
    logic       reject, reject_jam;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rej_cnt = 0;
    int jam_cnt = 0;
    int bad_cnt = 0;
    int codes[$];
    int code_cyc[$];

    coin_acceptor #(.DEBOUNCE_CYC(16), .GAP_CYC(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw), .hold(hold),
        .coin_code(coin_code), .reject(reject), .reject_jam(reject_jam), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record emitted codes and reject pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (coin_code != 2'b00) begin
                codes.push_back(int'(coin_code));
                code_cyc.push_back(cyc);
            end
            if (reject) rej_cnt++;
            if (reject_jam) jam_cnt++;
            if (coin_code == 2'b11 || (reject_jam && !reject)) bad_cnt++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic c5, input logic c10);
        coin5_raw  = c5;
        coin10_raw = c10;
        tick(20);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        tick(20);
    endtask

    task automatic clear_log();
        codes.delete();
        code_cyc.delete();
        rej_cnt = 0;
        jam_cnt = 0;
    endtask

    initial begin
        int c0;
        int seen;
        rst = 1'b1; coin5_raw = 1'b0; coin10_raw = 1'b0; hold = 1'b0;
        tick(3);
        check("rst_code", int'(coin_code), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_jam", int'(reject_jam), 0);
        check("rst_level", int'(fifo_level), 0);
        rst = 1'b0;
        tick(5);

        // 1: single 10Rs coin, code one cycle after edge 20
        clear_log();
        c0 = cyc;
        coin10_raw = 1'b1;
        tick(40);
        coin10_raw = 1'b0;
        tick(30);
        check("t1_ncodes", codes.size(), 1);
        if (codes.size() > 0) begin
            check("t1_code", codes[0], 2);
            check("t1_latency", code_cyc[0] - c0, 21);
        end
        check("t1_reject", rej_cnt, 0);

        // 2: short glitch is ignored
        clear_log();
        coin5_raw = 1'b1;
        tick(10);
        coin5_raw = 1'b0;
        tick(30);
        check("t2_ncodes", codes.size(), 0);
        check("t2_reject", rej_cnt, 0);
        check("t2_level", int'(fifo_level), 0);

        // 3: fill under hold, fifth coin rejected as full, then drain with spacing
        clear_log();
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            coin(1'b1, 1'b0);
            check($sformatf("t3_level%0d", i), int'(fifo_level), (i < 4) ? i : 4);
        end
        check("t3_reject", rej_cnt, 1);
        check("t3_jam", jam_cnt, 0);
        check("t3_ncodes_held", codes.size(), 0);
        hold = 1'b0;
        tick(30);
        check("t3_ncodes", codes.size(), 4);
        for (int i = 0; i < codes.size(); i++) begin
            check($sformatf("t3_code%0d", i), codes[i], 1);
            if (i > 0) check($sformatf("t3_space%0d", i), code_cyc[i] - code_cyc[i-1], 3);
        end
        check("t3_level_end", int'(fifo_level), 0);

        // 4: simultaneous 5Rs and 10Rs is a jam
        clear_log();
        coin5_raw = 1'b1; coin10_raw = 1'b1;
        tick(40);
        coin5_raw = 1'b0; coin10_raw = 1'b0;
        tick(25);
        check("t4_reject", rej_cnt, 1);
        check("t4_jam", jam_cnt, 1);
        check("t4_level", int'(fifo_level), 0);
        check("t4_ncodes", codes.size(), 0);

        // 5: order preserved
        clear_log();
        hold = 1'b1;
        coin(1'b1, 1'b0);
        coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        check("t5_level_held", int'(fifo_level), 3);
        hold = 1'b0;
        tick(30);
        check("t5_ncodes", codes.size(), 3);
        if (codes.size() == 3) begin
            check("t5_code0", codes[0], 1);
            check("t5_code1", codes[1], 2);
            check("t5_code2", codes[2], 1);
        end
        check("t5_level_end", int'(fifo_level), 0);

        // 6: reset with coins queued and a code in flight
        clear_log();
        hold = 1'b1;
        coin(1'b1, 1'b0);
        coin(1'b1, 1'b0);
        coin(1'b1, 1'b0);
        hold = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick(1);
            if (coin_code != 2'b00) seen = 1;
        end
        check("t6_code_seen", seen, 1);
        rst = 1'b1;
        tick(1);
        check("t6_code", int'(coin_code), 0);
        check("t6_reject", int'(reject), 0);
        check("t6_jam", int'(reject_jam), 0);
        check("t6_level", int'(fifo_level), 0);
        rst = 1'b0;
        clear_log();
        tick(40);
        check("t6_ncodes", codes.size(), 0);

        check("invariants", bad_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
